mmio_uart: RTL and testbench
============================

Name: mmio_uart

Overview:
- Memory-mapped UART peripheral on the CPU's MEM-stage data bus, alongside DataMemory.
- Consumes the MEM-stage bus fields: MemRead, MemWrite, Address (MEM ALU result) and Write_data (forwarded Rt data). Returns Read_data for the MEM/WB register.
- Provides a TX FIFO, a one-byte RX buffer, a status register and a serial TX/RX line pair.

Parameters:
CLK_FREQ, 100000000, core clock frequency in Hz
BAUD, 9600, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD, must be at least 4
TX_DEPTH, 4, TX FIFO entries, power of two
BASE_ADDR, 32'h4000_0018, byte address of the TXD register; word aligned

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
MemRead  in  1  MEM-stage load strobe
MemWrite  in  1  MEM-stage store strobe
Address  in  32  MEM-stage byte address
Write_data  in  32  store data
Read_data  out  32  load data, combinational
hit  out  1  Address is within BASE_ADDR..BASE_ADDR+8, so the top muxes Read_data
uart_rx  in  1  serial input, asynchronous to clk
uart_tx  out  1  serial output, idle high

Behaviour:
- Reset is asynchronous and active-high, effective immediately:
  - uart_tx=1, FIFO empty, TX and RX FSMs in IDLE, rx_valid=0, sticky flags=0, counters=0.
  - Read_data and hit follow inputs, no reset dependency.
  - Reset mid-frame aborts the frame with no partial byte kept.
- Register map (word offsets from BASE_ADDR):
  - +0 TXD: store pushes Write_data[7:0]; load returns 0.
  - +4 RXD: load returns {24'h0, rx_byte}; rx_valid clears at the clock edge ending the load cycle.
  - +8 STATUS: load returns {25'h0, frame_err, rx_overrun, tx_overflow, rx_valid, tx_busy, tx_empty, tx_full}. Store is write-1-to-clear for bits [6:4] only.
- Read_data = 0 whenever MemRead=0 or the address misses. Accesses are word-granular; Address[1:0] is ignored.
- TX FIFO:
  - A push is accepted if not full, or if the TX FSM pops in the same cycle.
  - Otherwise the byte is dropped and tx_overflow is set.
  - Pointers wrap modulo TX_DEPTH; a count register of width log2(TX_DEPTH)+1 drives full/empty.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into a shift register and go to START (pop cycle = entry cycle).
  - START: drive 0. DATA: drive bits LSB first, 8 bits. STOP: drive 1.
  - Each bit is held exactly CLKS_PER_BIT cycles via a baud counter that reloads on every bit boundary.
  - STOP goes to IDLE; back-to-back bytes therefore have no extra idle gap beyond one IDLE cycle.
  - tx_busy = state != IDLE.
- RX path: uart_rx passes through a 2-flop synchronizer.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a synchronized falling edge (level 0) goes to START.
  - START: wait CLKS_PER_BIT/2 cycles. If the line is still 0, go to DATA; else (glitch) return to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits LSB first.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Sampled 1: load rx_byte and set rx_valid. If rx_valid was already set and is not being cleared that cycle, set rx_overrun; the new byte overwrites.
    - Sampled 0: set frame_err and discard the byte.
  - STOP returns to IDLE.
- Simultaneous events:
  - RXD load in the same cycle a byte completes: the new byte loads, rx_valid stays 1, no overrun.
  - W1C clear and a new set of the same flag in the same cycle: set wins.
- Latency: a TXD store in cycle N with the FIFO empty and FSM idle puts the start bit on uart_tx from cycle N+2.

Optional Feature:
- MMIO_UART_IRQ_EN defined:
  - Adds output port irq (1 bit) and CTRL register at +12, holding bit0 rx_irq_en and bit1 tx_empty_irq_en; reset 0, read/write.
  - irq is registered and equals (rx_irq_en & rx_valid) | (tx_empty_irq_en & tx_empty & !tx_busy).
  - hit covers +12.
- Undefined: no irq port, +12 is unmapped (hit=0, Read_data=0).

Test Plan:
- CLK_FREQ=16, BAUD=1 (16 clks/bit). Store 0xA5 to BASE_ADDR → uart_tx sequence 0,1,0,1,0,0,1,0,1,1, each level held 16 cycles; tx_busy=1 throughout; STATUS returns 0x02 afterward.
- Store 5 bytes 0x01..0x05 back-to-back while idle → the first pops immediately and 4 are queued. A sixth store while full → tx_overflow=1 (STATUS bit4). Storing 0x10 to +8 clears it.
- Drive a 0x3C frame on uart_rx → rx_valid=1, a load at +4 returns 0x0000003C, and the next STATUS load shows bit3=0.
- Send two RX frames without reading → rx_overrun=1 and RXD holds the second byte. A frame with stop bit 0 → frame_err=1 and rx_valid unchanged.
- A 3-cycle low glitch on uart_rx → no byte, no flags. Assert reset during a TX data bit → uart_tx=1 immediately and FIFO empty.
- With MMIO_UART_IRQ_EN, write 0x1 to +12 and receive 0x55 → irq=1 one cycle after rx_valid rises; a load at +4 drops irq next cycle.

Source files
------------

// File: rtl/mmio_uart.sv
// Memory-mapped UART for the MEM-stage bus: TXD(+0), RXD(+4), STATUS(+8).
// Define MMIO_UART_IRQ_EN to add the CTRL register at +12 and the registered irq output.
module mmio_uart #(
   parameter int          CLK_FREQ  = 100000000,
   parameter int          BAUD      = 9600,
   parameter int          TX_DEPTH  = 4,
   parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Address,
   input  logic [31:0] Write_data,
   output logic [31:0] Read_data,
   output logic        hit,
   input  logic        uart_rx,
`ifdef MMIO_UART_IRQ_EN
   output logic        irq,
`endif
   output logic        uart_tx
);
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int PTR_W        = $clog2(TX_DEPTH);
   localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] BAUD_ZERO = CNT_W'(0);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(TX_DEPTH);
   localparam logic [29:0]      BASE_WORD = BASE_ADDR[31:2];
`ifdef MMIO_UART_IRQ_EN
   localparam logic [29:0]      NUM_REGS  = 30'd4;
`else
   localparam logic [29:0]      NUM_REGS  = 30'd3;
`endif

   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} uartState_t;

   uartState_t       txState_r, txNext_s, rxState_r, rxNext_s;
   logic [29:0]      wordOff_s;
   logic             txdWr_s, rxdRd_s, statWr_s;
   logic [7:0]       txMem_r [TX_DEPTH];
   logic [PTR_W-1:0] txWrPtr_r, txRdPtr_r;
   logic [PTR_W:0]   txCount_r;
   logic             txFull_s, txEmpty_s, txBusy_s, txPop_s, txPushOk_s, txBaudDone_s;
   logic [7:0]       txShift_r;
   logic [CNT_W-1:0] txBaud_r, rxBaud_r;
   logic [2:0]       txBit_r, rxBit_r;
   logic             txLine_r;
   logic [1:0]       rxSync_r;
   logic             rxLine_s, rxBaudDone_s, rxGood_s, rxBad_s;
   logic [7:0]       rxShift_r, rxByte_r;
   logic             rxValid_r, rxOverrun_r, txOverflow_r, frameErr_r;
   logic [31:0]      statusWord_s;
   logic             unusedBits_s;

   assign wordOff_s    = Address[31:2] - BASE_WORD;
   assign hit          = (wordOff_s < NUM_REGS);
   assign txdWr_s      = MemWrite & hit & (wordOff_s[1:0] == 2'd0);
   assign rxdRd_s      = MemRead  & hit & (wordOff_s[1:0] == 2'd1);
   assign statWr_s     = MemWrite & hit & (wordOff_s[1:0] == 2'd2);
   assign txFull_s     = (txCount_r == FIFO_FULL);
   assign txEmpty_s    = (txCount_r == {(PTR_W + 1){1'b0}});
   assign txBusy_s     = (txState_r != IDLE);
   assign txPushOk_s   = txdWr_s & (~txFull_s | txPop_s);
   assign txBaudDone_s = (txBaud_r == BAUD_ZERO);
   assign rxBaudDone_s = (rxBaud_r == BAUD_ZERO);
   assign rxLine_s     = rxSync_r[1];
   assign uart_tx      = txLine_r;
   assign statusWord_s = {25'h0, frameErr_r, rxOverrun_r, txOverflow_r, rxValid_r,
                          txBusy_s, txEmpty_s, txFull_s};
   assign unusedBits_s = ^{Write_data[31:8], Address[1:0]};

   // FIFO storage, pointers and occupancy; a push into a full FIFO is legal when the head pops
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         txWrPtr_r <= {PTR_W{1'b0}};
         txRdPtr_r <= {PTR_W{1'b0}};
         txCount_r <= {(PTR_W + 1){1'b0}};
         for (int i = 0; i < TX_DEPTH; i++) txMem_r[i] <= 8'h00;
      end else begin
         if (txPushOk_s) begin
            txMem_r[txWrPtr_r] <= Write_data[7:0];
            txWrPtr_r          <= txWrPtr_r + PTR_ONE;
         end
         if (txPop_s) txRdPtr_r <= txRdPtr_r + PTR_ONE;
         case ({txPushOk_s, txPop_s})
            2'b10:   txCount_r <= txCount_r + CNT_ONE;
            2'b01:   txCount_r <= txCount_r - CNT_ONE;
            default: txCount_r <= txCount_r;
         endcase
      end
   end

   // State registers for both FSMs and the two-flop RX synchronizer (idles high)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         txState_r <= IDLE;
         rxState_r <= IDLE;
         rxSync_r  <= 2'b11;
      end else begin
         txState_r <= txNext_s;
         rxState_r <= rxNext_s;
         rxSync_r  <= {rxSync_r[0], uart_rx};
      end
   end

   // TX next state; the pop happens in the IDLE cycle that launches the frame
   always_comb begin
      txNext_s = txState_r;
      txPop_s  = 1'b0;
      case (txState_r)
         IDLE:  if (!txEmpty_s) begin txNext_s = START; txPop_s = 1'b1; end
                else txNext_s = IDLE;
         START: if (txBaudDone_s) txNext_s = DATA; else txNext_s = START;
         DATA:  if (txBaudDone_s && (txBit_r == 3'd7)) txNext_s = STOP; else txNext_s = DATA;
         STOP:  if (txBaudDone_s) txNext_s = IDLE; else txNext_s = STOP;
         default: txNext_s = IDLE;
      endcase
   end

   // TX datapath: the line register is updated at each bit boundary so uart_tx is glitch-free
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         txLine_r  <= 1'b1;
         txShift_r <= 8'h00;
         txBaud_r  <= BAUD_ZERO;
         txBit_r   <= 3'd0;
      end else begin
         case (txState_r)
            IDLE: if (txPop_s) begin
               txShift_r <= txMem_r[txRdPtr_r];
               txBaud_r  <= BIT_LAST;
               txBit_r   <= 3'd0;
               txLine_r  <= 1'b0;
            end
            START, DATA: if (txBaudDone_s) begin
               txBaud_r <= BIT_LAST;
               if ((txState_r == DATA) && (txBit_r == 3'd7)) begin
                  txLine_r <= 1'b1;
               end else begin
                  txLine_r  <= txShift_r[0];
                  txShift_r <= {1'b0, txShift_r[7:1]};
               end
               if (txState_r == DATA) txBit_r <= txBit_r + 3'd1;
            end else begin
               txBaud_r <= txBaud_r - BAUD_ONE;
            end
            STOP: if (!txBaudDone_s) txBaud_r <= txBaud_r - BAUD_ONE;
            default: txLine_r <= 1'b1;
         endcase
      end
   end

   // RX next state; a start bit that is high again at mid-bit is treated as a glitch
   always_comb begin
      rxNext_s = rxState_r;
      rxGood_s = 1'b0;
      rxBad_s  = 1'b0;
      case (rxState_r)
         IDLE:  if (!rxLine_s) rxNext_s = START; else rxNext_s = IDLE;
         START: if (rxBaudDone_s) begin
                   if (!rxLine_s) rxNext_s = DATA; else rxNext_s = IDLE;
                end else rxNext_s = START;
         DATA:  if (rxBaudDone_s && (rxBit_r == 3'd7)) rxNext_s = STOP; else rxNext_s = DATA;
         STOP:  if (rxBaudDone_s) begin
                   rxNext_s = IDLE;
                   if (rxLine_s) rxGood_s = 1'b1; else rxBad_s = 1'b1;
                end else rxNext_s = STOP;
         default: rxNext_s = IDLE;
      endcase
   end

   // RX datapath: mid-bit sampling, LSB first
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rxBaud_r  <= BAUD_ZERO;
         rxBit_r   <= 3'd0;
         rxShift_r <= 8'h00;
         rxByte_r  <= 8'h00;
      end else begin
         case (rxState_r)
            IDLE:  if (!rxLine_s) rxBaud_r <= HALF_LAST;
            START: if (rxBaudDone_s) begin
                      rxBaud_r <= BIT_LAST;
                      rxBit_r  <= 3'd0;
                   end else rxBaud_r <= rxBaud_r - BAUD_ONE;
            DATA:  if (rxBaudDone_s) begin
                      rxBaud_r  <= BIT_LAST;
                      rxShift_r <= {rxLine_s, rxShift_r[7:1]};
                      rxBit_r   <= rxBit_r + 3'd1;
                   end else rxBaud_r <= rxBaud_r - BAUD_ONE;
            STOP:  if (!rxBaudDone_s) rxBaud_r <= rxBaud_r - BAUD_ONE;
            default: rxBaud_r <= BAUD_ZERO;
         endcase
         if (rxGood_s) rxByte_r <= rxShift_r;
      end
   end

   // Receive-valid and sticky flags; a new set beats a same-cycle write-1-to-clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rxValid_r    <= 1'b0;
         rxOverrun_r  <= 1'b0;
         txOverflow_r <= 1'b0;
         frameErr_r   <= 1'b0;
      end else begin
         if (rxGood_s)     rxValid_r <= 1'b1;
         else if (rxdRd_s) rxValid_r <= 1'b0;
         rxOverrun_r  <= (rxGood_s & rxValid_r & ~rxdRd_s)
                         | (rxOverrun_r & ~(statWr_s & Write_data[5]));
         txOverflow_r <= (txdWr_s & ~txPushOk_s) | (txOverflow_r & ~(statWr_s & Write_data[4]));
         frameErr_r   <= rxBad_s | (frameErr_r & ~(statWr_s & Write_data[6]));
      end
   end

`ifdef MMIO_UART_IRQ_EN
   logic [1:0] ctrl_r;
   logic       irq_r;
   assign irq = irq_r;

   // CTRL register (bit0 rx_irq_en, bit1 tx_empty_irq_en) and the registered interrupt
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_r <= 2'b00;
         irq_r  <= 1'b0;
      end else begin
         if (MemWrite && hit && (wordOff_s[1:0] == 2'd3)) ctrl_r <= Write_data[1:0];
         irq_r <= (ctrl_r[0] & rxValid_r) | (ctrl_r[1] & txEmpty_s & ~txBusy_s);
      end
   end
`endif

   // Load data mux; zero on a miss or when no load is in progress
   always_comb begin
      Read_data = 32'h0;
      if (MemRead && hit) begin
         case (wordOff_s[1:0])
            2'd1:    Read_data = {24'h0, rxByte_r};
            2'd2:    Read_data = statusWord_s;
`ifdef MMIO_UART_IRQ_EN
            2'd3:    Read_data = {30'h0, ctrl_r};
`endif
            default: Read_data = 32'h0;
         endcase
      end else begin
         Read_data = 32'h0;
      end
   end
endmodule

// File: tb/tb_mmio_uart.sv
// Directed bench for mmio_uart at 16 clocks per bit, default build (no irq port).
module tb_mmio_uart;
   localparam logic [31:0] BASE = 32'h4000_0018;
   localparam int          CPB  = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead, MemWrite;
   logic [31:0] Address, Write_data, Read_data;
   logic        hit, uart_rx, uart_tx;
   int          vecCount = 0;
   int          errCount = 0;
   int          cyc = 0;

   mmio_uart #(.CLK_FREQ(16), .BAUD(1), .TX_DEPTH(4), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .Address(Address), .Write_data(Write_data), .Read_data(Read_data),
      .hit(hit), .uart_rx(uart_rx), .uart_tx(uart_tx));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      MemWrite = 1'b1; Address = addr; Write_data = data;
      @(posedge clk);
      #1 MemWrite = 1'b0;
   endtask

   task automatic busRead(input logic [31:0] addr, output logic [31:0] data, output logic hitV);
      @(negedge clk);
      MemRead = 1'b1; Address = addr;
      #1 data = Read_data; hitV = hit;
      @(posedge clk);
      #1 MemRead = 1'b0;
   endtask

   task automatic sendFrame(input logic [7:0] b, input logic stopBit);
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = stopBit;
      repeat (stopBit ? CPB : 10) @(negedge clk);
      uart_rx = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] rd; logic h;
      repeat (3) @(negedge clk);
      vecCount++;
      if (uart_tx !== 1'b1) begin errCount++; $display("FAIL reset_tx got %b want 1", uart_tx); end
      @(negedge clk) reset = 1'b0;
      busRead(BASE + 32'd8, rd, h);
      vecCount++;
      if (rd !== 32'h02 || h !== 1'b1) begin
         errCount++; $display("FAIL reset_status got %h hit %b want 00000002 hit 1", rd, h);
      end
   endtask

   task automatic test_decode();
      logic [31:0] rd; logic h;
      busRead(BASE + 32'd12, rd, h);
      vecCount++;
      if (rd !== 32'h0 || h !== 1'b0) begin errCount++; $display("FAIL unmapped12 got %h hit %b want 0 hit 0", rd, h); end
      busRead(BASE - 32'd4, rd, h);
      vecCount++;
      if (rd !== 32'h0 || h !== 1'b0) begin errCount++; $display("FAIL below_base got %h hit %b want 0 hit 0", rd, h); end
      busRead(BASE, rd, h);
      vecCount++;
      if (rd !== 32'h0 || h !== 1'b1) begin errCount++; $display("FAIL txd_load got %h hit %b want 0 hit 1", rd, h); end
      busRead(BASE + 32'd11, rd, h);
      vecCount++;
      if (rd !== 32'h02) begin errCount++; $display("FAIL status_lowbits got %h want 00000002", rd); end
      @(negedge clk);
      MemRead = 1'b0; Address = BASE + 32'd8;
      #1;
      vecCount++;
      if (Read_data !== 32'h0 || hit !== 1'b1) begin
         errCount++; $display("FAIL no_read got %h hit %b want 0 hit 1", Read_data, hit);
      end
   endtask

   task automatic test_tx_frame();
      logic [31:0] rd; logic h;
      logic [9:0] frame;
      frame = {1'b1, 8'hA5, 1'b0};
      fork
         begin
            int bad;
            busWrite(BASE, 32'h0000_00A5);
            @(negedge clk);
            vecCount++;
            if (uart_tx !== 1'b1) begin errCount++; $display("FAIL tx_latency got %b want 1", uart_tx); end
            for (int j = 0; j < 10; j++) begin
               bad = 0;
               for (int c = 0; c < CPB; c++) begin
                  @(negedge clk);
                  if (uart_tx !== frame[j]) bad++;
               end
               vecCount++;
               if (bad != 0) begin
                  errCount++; $display("FAIL tx_bit%0d got %0d wrong cycles want level %b for 16", j, bad, frame[j]);
               end
            end
         end
         begin
            logic [31:0] mrd; logic mh;
            repeat (60) @(negedge clk);
            busRead(BASE + 32'd8, mrd, mh);
            vecCount++;
            if (mrd !== 32'h06) begin errCount++; $display("FAIL tx_busy_status got %h want 00000006", mrd); end
         end
      join
      busRead(BASE + 32'd8, rd, h);
      vecCount++;
      if (rd !== 32'h02) begin errCount++; $display("FAIL tx_done_status got %h want 00000002", rd); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic h;
      int startCyc [5];
      int lows;
      fork
         begin
            int waited;
            logic [7:0] got;
            for (int k = 0; k < 5; k++) begin
               waited = 0;
               got = 8'h00;
               while (uart_tx !== 1'b0 && waited < 2000) begin @(negedge clk); waited++; end
               startCyc[k] = cyc;
               vecCount++;
               if (waited >= 2000) begin errCount++; $display("FAIL b2b_start%0d got timeout want start bit", k); end
               repeat (8) @(negedge clk);
               for (int i = 0; i < 8; i++) begin
                  repeat (CPB) @(negedge clk);
                  got[i] = uart_tx;
               end
               repeat (CPB) @(negedge clk);
               vecCount++;
               if (got !== 8'(k + 1) || uart_tx !== 1'b1) begin
                  errCount++; $display("FAIL b2b_byte%0d got %h stop %b want %h stop 1", k, got, uart_tx, 8'(k + 1));
               end
            end
         end
         begin
            for (int k = 0; k < 5; k++) busWrite(BASE, 32'(k + 1));
            busWrite(BASE, 32'h0000_0006);
            busRead(BASE + 32'd8, rd, h);
            vecCount++;
            if (rd !== 32'h15) begin errCount++; $display("FAIL overflow_status got %h want 00000015", rd); end
            busWrite(BASE + 32'd8, 32'h0000_0010);
            busRead(BASE + 32'd8, rd, h);
            vecCount++;
            if (rd !== 32'h05) begin errCount++; $display("FAIL overflow_w1c got %h want 00000005", rd); end
         end
      join
      for (int k = 1; k < 5; k++) begin
         vecCount++;
         if (startCyc[k] - startCyc[k-1] !== 161) begin
            errCount++; $display("FAIL b2b_gap%0d got %0d want 161", k, startCyc[k] - startCyc[k-1]);
         end
      end
      lows = 0;
      repeat (200) begin @(negedge clk); if (uart_tx !== 1'b1) lows++; end
      vecCount++;
      if (lows != 0) begin errCount++; $display("FAIL b2b_no_sixth got %0d low cycles want 0", lows); end
   endtask

   task automatic test_rx_basic();
      logic [31:0] rd; logic h;
      sendFrame(8'h3C, 1'b1);
      busRead(BASE + 32'd8, rd, h);
      vecCount++;
      if (rd !== 32'h0A) begin errCount++; $display("FAIL rx_valid_status got %h want 0000000A", rd); end
      busRead(BASE + 32'd4, rd, h);
      vecCount++;
      if (rd !== 32'h3C) begin errCount++; $display("FAIL rx_data got %h want 0000003C", rd); end
      busRead(BASE + 32'd8, rd, h);
      vecCount++;
      if (rd !== 32'h02) begin errCount++; $display("FAIL rx_cleared_status got %h want 00000002", rd); end
   endtask

   task automatic test_rx_overrun_ferr();
      logic [31:0] rd; logic h;
      sendFrame(8'h11, 1'b1);
      sendFrame(8'h22, 1'b1);
      busRead(BASE + 32'd8, rd, h);
      vecCount++;
      if (rd !== 32'h2A) begin errCount++; $display("FAIL overrun_status got %h want 0000002A", rd); end
      sendFrame(8'h77, 1'b0);
      busRead(BASE + 32'd8, rd, h);
      vecCount++;
      if (rd !== 32'h6A) begin errCount++; $display("FAIL ferr_status got %h want 0000006A", rd); end
      busRead(BASE + 32'd4, rd, h);
      vecCount++;
      if (rd !== 32'h22) begin errCount++; $display("FAIL overrun_data got %h want 00000022", rd); end
      busRead(BASE + 32'd8, rd, h);
      vecCount++;
      if (rd !== 32'h62) begin errCount++; $display("FAIL flags_after_read got %h want 00000062", rd); end
      busWrite(BASE + 32'd8, 32'h0000_0070);
      busRead(BASE + 32'd8, rd, h);
      vecCount++;
      if (rd !== 32'h02) begin errCount++; $display("FAIL w1c_all got %h want 00000002", rd); end
   endtask

   task automatic test_rx_glitch();
      logic [31:0] rd; logic h;
      @(negedge clk) uart_rx = 1'b0;
      repeat (3) @(negedge clk);
      uart_rx = 1'b1;
      repeat (40) @(negedge clk);
      busRead(BASE + 32'd8, rd, h);
      vecCount++;
      if (rd !== 32'h02) begin errCount++; $display("FAIL glitch_status got %h want 00000002", rd); end
      busRead(BASE + 32'd4, rd, h);
      vecCount++;
      if (rd !== 32'h22) begin errCount++; $display("FAIL glitch_data got %h want 00000022", rd); end
   endtask

   task automatic test_reset_mid_tx();
      logic [31:0] rd; logic h;
      int lows;
      busWrite(BASE, 32'h0);
      busWrite(BASE, 32'h0);
      repeat (40) @(negedge clk);
      vecCount++;
      if (uart_tx !== 1'b0) begin errCount++; $display("FAIL midtx_level got %b want 0", uart_tx); end
      #1 reset = 1'b1;
      #1;
      vecCount++;
      if (uart_tx !== 1'b1) begin errCount++; $display("FAIL async_reset_tx got %b want 1", uart_tx); end
      busRead(BASE + 32'd8, rd, h);
      vecCount++;
      if (rd !== 32'h02) begin errCount++; $display("FAIL reset_fifo_status got %h want 00000002", rd); end
      @(negedge clk) reset = 1'b0;
      lows = 0;
      repeat (200) begin @(negedge clk); if (uart_tx !== 1'b1) lows++; end
      vecCount++;
      if (lows != 0) begin errCount++; $display("FAIL post_reset_idle got %0d low cycles want 0", lows); end
      busRead(BASE + 32'd8, rd, h);
      vecCount++;
      if (rd !== 32'h02) begin errCount++; $display("FAIL post_reset_status got %h want 00000002", rd); end
   endtask

   initial begin
      reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
      Address = 32'h0; Write_data = 32'h0; uart_rx = 1'b1;
      test_reset();
      test_decode();
      test_tx_frame();
      test_back_to_back();
      test_rx_basic();
      test_rx_overrun_ferr();
      test_rx_glitch();
      test_reset_mid_tx();
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end
endmodule
